// File: rtl/chacha20_pkg.sv
// Shared types, constants and round index tables for the ChaCha20 block core.
package chacha20_pkg;

  typedef logic [31:0]           chacha_word_t;
  typedef chacha_word_t [15:0]   chacha_state_t;
  typedef logic [3:0]            chacha_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_ADD,
    ST_DONE
  } chacha_fsm_e;

  localparam chacha_word_t SIGMA0 = 32'h61707865;
  localparam chacha_word_t SIGMA1 = 32'h3320646e;
  localparam chacha_word_t SIGMA2 = 32'h79622d32;
  localparam chacha_word_t SIGMA3 = 32'h6b206574;

  localparam int ROUNDS_8  = 8;
  localparam int ROUNDS_12 = 12;
  localparam int ROUNDS_20 = 20;

  // Entry [4*q + pos] is the state word feeding operand pos (a,b,c,d) of quarterround q.
  localparam chacha_idx_t [15:0] COL_IDX = {
    4'd15, 4'd11, 4'd7, 4'd3,
    4'd14, 4'd10, 4'd6, 4'd2,
    4'd13, 4'd9,  4'd5, 4'd1,
    4'd12, 4'd8,  4'd4, 4'd0
  };

  localparam chacha_idx_t [15:0] DIAG_IDX = {
    4'd14, 4'd9,  4'd4, 4'd3,
    4'd13, 4'd8,  4'd7, 4'd2,
    4'd12, 4'd11, 4'd6, 4'd1,
    4'd15, 4'd10, 4'd5, 4'd0
  };

  function automatic bit rounds_legal(input int r);
    return (r == ROUNDS_8) || (r == ROUNDS_12) || (r == ROUNDS_20);
  endfunction

  function automatic chacha_word_t rotl(input chacha_word_t x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

endpackage

// File: rtl/chacha20_block_core_if.sv
// Request/response handshake bundle for chacha20_block_core (in_text only with CHACHA20_KS_XOR_EN).
interface chacha20_block_core_if;

  logic         in_valid;
  logic         in_ready;
  logic [255:0] in_key;
  logic [31:0]  in_counter;
  logic [95:0]  in_nonce;
`ifdef CHACHA20_KS_XOR_EN
  logic [511:0] in_text;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [511:0] out_data;

  modport master (
`ifdef CHACHA20_KS_XOR_EN
    output in_text,
`endif
    output in_valid, in_key, in_counter, in_nonce, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
`ifdef CHACHA20_KS_XOR_EN
    input  in_text,
`endif
    input  in_valid, in_key, in_counter, in_nonce, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/chacha20_block_core_qr.sv
// Purely combinational ChaCha20 quarterround, all arithmetic mod 2^32.
module chacha20_qr
  import chacha20_pkg::*;
(
  input  chacha_word_t a_i,
  input  chacha_word_t b_i,
  input  chacha_word_t c_i,
  input  chacha_word_t d_i,
  output chacha_word_t a_o,
  output chacha_word_t b_o,
  output chacha_word_t c_o,
  output chacha_word_t d_o
);

  chacha_word_t a1, b1, c1, d1;
  chacha_word_t a2, b2, c2, d2;

  assign a1 = a_i + b_i;
  assign d1 = rotl(d_i ^ a1, 16);
  assign c1 = c_i + d1;
  assign b1 = rotl(b_i ^ c1, 12);
  assign a2 = a1 + b1;
  assign d2 = rotl(d1 ^ a2, 8);
  assign c2 = c1 + d2;
  assign b2 = rotl(b1 ^ c2, 7);

  assign a_o = a2;
  assign b_o = b2;
  assign c_o = c2;
  assign d_o = d2;

endmodule

// File: rtl/chacha20_block_core.sv
// Iterative ChaCha20 block function, one round per cycle on four quarterrounds.
// Define CHACHA20_KS_XOR_EN to XOR a captured text block into the output.
module chacha20_block_core
  import chacha20_pkg::*;
#(
  parameter int ROUNDS = 20
) (
  input logic                  clk,
  input logic                  rst_n,
  chacha20_block_core_if.slave bus
);

  if (!rounds_legal(ROUNDS)) begin : g_bad_rounds
    $error("chacha20_block_core: ROUNDS must be 8, 12 or 20");
  end

  localparam logic [4:0] LAST_ROUND = 5'(ROUNDS - 1);

  chacha_fsm_e   state_q, state_d;
  logic [4:0]    round_cnt_q, round_cnt_d;
  chacha_state_t work_q, work_d;
  chacha_state_t init_q, init_d;
  chacha_state_t out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
`ifdef CHACHA20_KS_XOR_EN
  logic [511:0]  text_q, text_d;
`endif

  chacha_state_t      req_state;
  chacha_state_t      round_state;
  chacha_state_t      sum_state;
  chacha_idx_t [15:0] idx_tbl;
  chacha_word_t       qa_i [4], qb_i [4], qc_i [4], qd_i [4];
  chacha_word_t       qa_o [4], qb_o [4], qc_o [4], qd_o [4];

  assign req_state = {bus.in_nonce, bus.in_counter, bus.in_key, SIGMA3, SIGMA2, SIGMA1, SIGMA0};
  assign idx_tbl   = round_cnt_q[0] ? DIAG_IDX : COL_IDX;

  always_comb begin
    for (int q = 0; q < 4; q++) begin
      qa_i[q] = work_q[idx_tbl[4*q]];
      qb_i[q] = work_q[idx_tbl[4*q+1]];
      qc_i[q] = work_q[idx_tbl[4*q+2]];
      qd_i[q] = work_q[idx_tbl[4*q+3]];
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_qr
    chacha20_qr u_qr (
      .a_i (qa_i[g]), .b_i (qb_i[g]), .c_i (qc_i[g]), .d_i (qd_i[g]),
      .a_o (qa_o[g]), .b_o (qb_o[g]), .c_o (qc_o[g]), .d_o (qd_o[g])
    );
  end

  // Each round permutes disjoint word sets, so every word is written back exactly once.
  always_comb begin
    round_state = work_q;
    for (int q = 0; q < 4; q++) begin
      round_state[idx_tbl[4*q]]   = qa_o[q];
      round_state[idx_tbl[4*q+1]] = qb_o[q];
      round_state[idx_tbl[4*q+2]] = qc_o[q];
      round_state[idx_tbl[4*q+3]] = qd_o[q];
    end
  end

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      sum_state[i] = work_q[i] + init_q[i];
    end
  end

  always_comb begin
    state_d     = state_q;
    round_cnt_d = round_cnt_q;
    work_d      = work_q;
    init_d      = init_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
`ifdef CHACHA20_KS_XOR_EN
    text_d      = text_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          init_d      = req_state;
          work_d      = req_state;
          round_cnt_d = '0;
`ifdef CHACHA20_KS_XOR_EN
          text_d      = bus.in_text;
`endif
          state_d     = ST_RUN;
        end
      end
      ST_RUN: begin
        work_d      = round_state;
        round_cnt_d = round_cnt_q + 5'd1;
        if (round_cnt_q == LAST_ROUND) begin
          state_d = ST_ADD;
        end
      end
      ST_ADD: begin
`ifdef CHACHA20_KS_XOR_EN
        out_data_d  = sum_state ^ text_q;
`else
        out_data_d  = sum_state;
`endif
        out_valid_d = 1'b1;
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      round_cnt_q <= '0;
      work_q      <= '0;
      init_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
`ifdef CHACHA20_KS_XOR_EN
      text_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      round_cnt_q <= round_cnt_d;
      work_q      <= work_d;
      init_q      <= init_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
`ifdef CHACHA20_KS_XOR_EN
      text_q      <= text_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_chacha20_block_core.sv
// Directed-vector bench for chacha20_block_core and chacha20_qr.
module tb_chacha20_block_core;

  localparam int ROUNDS = 20;
  localparam int QI [8][4] = '{
    '{0, 4, 8, 12}, '{1, 5, 9, 13}, '{2, 6, 10, 14}, '{3, 7, 11, 15},
    '{0, 5, 10, 15}, '{1, 6, 11, 12}, '{2, 7, 8, 13}, '{3, 4, 9, 14}
  };

  typedef struct {
    logic [255:0] key;
    logic [31:0]  ctr;
    logic [95:0]  nonce;
    logic         has_kat;
    logic [31:0]  kat_w0;
    logic [31:0]  kat_w15;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  logic [31:0] qa, qb, qc, qd, ra, rb, rc, rd;

  chacha20_block_core_if bus ();
`ifdef CHACHA20_KS_XOR_EN
  logic [511:0] tb_text;
  assign bus.in_text = tb_text;
`endif

  chacha20_block_core #(.ROUNDS(ROUNDS)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  chacha20_qr u_qr (.a_i(qa), .b_i(qb), .c_i(qc), .d_i(qd),
                    .a_o(ra), .b_o(rb), .c_o(rc), .d_o(rd));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] rl(input logic [31:0] v, input int s);
    return (v << s) | (v >> (32 - s));
  endfunction

  function automatic logic [127:0] ref_qr(input logic [31:0] a0, b0, c0, d0);
    logic [31:0] a, b, c, d;
    a = a0; b = b0; c = c0; d = d0;
    a = a + b; d = rl(d ^ a, 16);
    c = c + d; b = rl(b ^ c, 12);
    a = a + b; d = rl(d ^ a, 8);
    c = c + d; b = rl(b ^ c, 7);
    return {a, b, c, d};
  endfunction

  function automatic logic [511:0] chacha_ref(input logic [255:0] k, input logic [31:0] c,
                                              input logic [95:0] n);
    logic [31:0]  s [16];
    logic [31:0]  x [16];
    logic [127:0] r;
    logic [511:0] o;
    s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) s[4+i] = k[32*i +: 32];
    s[12] = c;
    for (int i = 0; i < 3; i++) s[13+i] = n[32*i +: 32];
    x = s;
    for (int dr = 0; dr < ROUNDS / 2; dr++) begin
      for (int j = 0; j < 8; j++) begin
        r = ref_qr(x[QI[j][0]], x[QI[j][1]], x[QI[j][2]], x[QI[j][3]]);
        x[QI[j][0]] = r[127:96];
        x[QI[j][1]] = r[95:64];
        x[QI[j][2]] = r[63:32];
        x[QI[j][3]] = r[31:0];
      end
    end
    for (int i = 0; i < 16; i++) o[32*i +: 32] = x[i] + s[i];
    return o;
  endfunction

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic issue(input logic [255:0] k, input logic [31:0] c, input logic [95:0] n);
    int g;
    bus.in_key     = k;
    bus.in_counter = c;
    bus.in_nonce   = n;
    bus.in_valid   = 1'b1;
    g = 0;
    while (!bus.in_ready && g < 50) begin
      @(posedge clk); #1; g++;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!bus.out_valid && lat < 100);
  endtask

  task automatic finish_out();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  logic [255:0] k_rfc;
  logic [95:0]  n_rfc;
  logic [511:0] blk_rfc;
  logic [511:0] exp_blk;
  logic [511:0] held;
  vec_t         vecs [5];
  int           lat;

  initial begin
    k_rfc   = {32'h1f1e1d1c, 32'h1b1a1918, 32'h17161514, 32'h13121110,
               32'h0f0e0d0c, 32'h0b0a0908, 32'h07060504, 32'h03020100};
    n_rfc   = {32'h00000000, 32'h4a000000, 32'h09000000};
    blk_rfc = {32'h4e3c50a2, 32'he883d0cb, 32'hb94e16de, 32'hd19c12b5,
               32'ha2028bd9, 32'h05d7c214, 32'h09aa9f07, 32'h466482d2,
               32'h4e6cd4c3, 32'h9aaa2204, 32'h0368c033, 32'hc7f4d1c7,
               32'hc47120a3, 32'h1fdd0f50, 32'h15593bd1, 32'he4e7f110};

    vecs[0] = '{k_rfc, 32'd1, n_rfc, 1'b1, 32'he4e7f110, 32'h4e3c50a2};
    vecs[1] = '{256'd0, 32'd0, 96'd0, 1'b1, 32'hade0b876, 32'h8665eeb2};
    vecs[2] = '{256'd0, 32'd1, 96'd0, 1'b0, 32'd0, 32'd0};
    vecs[3] = '{256'd0, 32'hffffffff, 96'd0, 1'b0, 32'd0, 32'd0};
    vecs[4] = '{256'hdeadbeef_01234567_89abcdef_fedcba98_76543210_a5a5a5a5_5a5a5a5a_c001d00d,
                32'h12345678, 96'h01234567_89abcdef_00112233, 1'b0, 32'd0, 32'd0};

    bus.in_valid = 1'b0; bus.in_key = '0; bus.in_counter = '0; bus.in_nonce = '0;
    bus.out_ready = 1'b0;
`ifdef CHACHA20_KS_XOR_EN
    tb_text = '0;
`endif
    qa = 32'h11111111; qb = 32'h01020304; qc = 32'h9b8d6f43; qd = 32'h01234567;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chkb("reset_out_valid", bus.out_valid, 1'b0);
    chkb("reset_in_ready", bus.in_ready, 1'b1);
    chk("reset_out_data", bus.out_data, 512'd0);
    chk("qr_rfc_2_1_1", 512'({ra, rb, rc, rd}),
        512'({32'hea2a92f4, 32'hcb1cf8ce, 32'h4581472e, 32'h5881c4bb}));
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 5; v++) begin
      issue(vecs[v].key, vecs[v].ctr, vecs[v].nonce);
      wait_out(lat);
      chkw("latency", 32'(lat), 32'(ROUNDS + 1));
      exp_blk = chacha_ref(vecs[v].key, vecs[v].ctr, vecs[v].nonce);
      chk("block_vs_model", bus.out_data, exp_blk);
      if (vecs[v].has_kat) begin
        chkw("kat_word0", bus.out_data[31:0], vecs[v].kat_w0);
        chkw("kat_word15", bus.out_data[511:480], vecs[v].kat_w15);
      end
      if (v == 0) chk("rfc_2_3_2_block", bus.out_data, blk_rfc);
      finish_out();
      chkb("after_hs_out_valid", bus.out_valid, 1'b0);
      chkb("after_hs_in_ready", bus.in_ready, 1'b1);
      chk("after_hs_data_held", bus.out_data, exp_blk);
    end

    // Backpressure: stall in DONE with a competing request on the input.
    issue(k_rfc, 32'd1, n_rfc);
    wait_out(lat);
    held = bus.out_data;
    chk("stall_start_data", held, blk_rfc);
    bus.in_key = '1; bus.in_counter = 32'h55; bus.in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      chk("stall_data", bus.out_data, blk_rfc);
      chkb("stall_out_valid", bus.out_valid, 1'b1);
      chkb("stall_in_ready", bus.in_ready, 1'b0);
    end
    bus.in_valid = 1'b0;
    finish_out();
    chkb("release_out_valid", bus.out_valid, 1'b0);
    chkb("release_in_ready", bus.in_ready, 1'b1);
    chk("release_data_held", bus.out_data, blk_rfc);
    repeat (3) begin
      @(posedge clk); #1;
      chkb("no_late_accept", bus.in_ready, 1'b1);
    end

    // out_ready already high when out_valid rises: exactly one valid cycle.
    bus.out_ready = 1'b1;
    issue(vecs[1].key, vecs[1].ctr, vecs[1].nonce);
    wait_out(lat);
    chkw("early_ready_latency", 32'(lat), 32'(ROUNDS + 1));
    chkw("early_ready_word0", bus.out_data[31:0], 32'hade0b876);
    @(posedge clk); #1;
    chkb("early_ready_one_cycle", bus.out_valid, 1'b0);
    chkb("early_ready_in_ready", bus.in_ready, 1'b1);
    bus.out_ready = 1'b0;

    // Asynchronous reset in the middle of the round loop.
    issue(vecs[4].key, vecs[4].ctr, vecs[4].nonce);
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chkb("midrun_rst_out_valid", bus.out_valid, 1'b0);
    chkb("midrun_rst_in_ready", bus.in_ready, 1'b1);
    chk("midrun_rst_out_data", bus.out_data, 512'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chkb("post_rst_in_ready", bus.in_ready, 1'b1);
    chkb("post_rst_out_valid", bus.out_valid, 1'b0);
    issue(k_rfc, 32'd1, n_rfc);
    wait_out(lat);
    chkw("post_rst_latency", 32'(lat), 32'(ROUNDS + 1));
    chk("post_rst_block", bus.out_data, blk_rfc);
    finish_out();

`ifdef CHACHA20_KS_XOR_EN
    tb_text = blk_rfc;
    issue(k_rfc, 32'd1, n_rfc);
    tb_text = '1;
    wait_out(lat);
    chk("xor_self_zero", bus.out_data, 512'd0);
    finish_out();
    tb_text = {16{32'h0f1e2d3c}};
    issue(k_rfc, 32'd1, n_rfc);
    wait_out(lat);
    chk("xor_pattern", bus.out_data, blk_rfc ^ {16{32'h0f1e2d3c}});
    finish_out();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
